// File: rtl/fpcvt_arb.sv
// Round-robin front end sharing one external FPCVT converter between N_REQ requesters.
// Grants one operand, captures the converter's S/E/F one cycle later, holds it until consumed.
//
// state | meaning
// IDLE  | no transaction; grant the round-robin winner if any req is set
// CONV  | cvt_d holds the granted operand; capture S/E/F at the next edge
// HOLD  | response valid; wait for rsp_ready, optionally granting the next winner
module fpcvt_arb #(
  parameter int N_REQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [12*N_REQ-1:0] din,
  output logic [N_REQ-1:0]    gnt,
  output logic [11:0]         cvt_d,
  input  logic                cvt_s,
  input  logic [2:0]          cvt_e,
  input  logic [3:0]          cvt_f,
  output logic                rsp_valid,
  output logic [1:0]          rsp_id,
  output logic                rsp_s,
  output logic [2:0]          rsp_e,
  output logic [3:0]          rsp_f,
  input  logic                rsp_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  id_q, id_d;
  logic [11:0] cvt_d_q, cvt_d_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_id_q, rsp_id_d;
  logic        rsp_s_q, rsp_s_d;
  logic [2:0]  rsp_e_q, rsp_e_d;
  logic [3:0]  rsp_f_q, rsp_f_d;

  logic        found;
  logic [1:0]  win;
  logic [1:0]  win_nxt;
  logic [11:0] win_op;
  logic        grant_en;
  logic        take;

  // Search starts at ptr_q and wraps; first asserted requester wins.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ((int'(ptr_q) + k) >= N_REQ) ? (int'(ptr_q) + k - N_REQ) : (int'(ptr_q) + k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  assign win_nxt  = (int'(win) == N_REQ - 1) ? 2'd0 : win + 2'd1;
  assign win_op   = din[12*win +: 12];
  // rst_n gates the strobe so nothing is accepted while reset is held.
  assign grant_en = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && rsp_ready));
  assign take     = grant_en && found;
  assign gnt      = take ? (N_REQ'(1) << win) : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cvt_d_d     = cvt_d_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_e_d     = rsp_e_q;
    rsp_f_d     = rsp_f_q;

    case (state_q)
      IDLE: begin
        if (take) begin
          cvt_d_d = win_op;
          id_d    = win;
          ptr_d   = win_nxt;
          state_d = CONV;
        end
      end
      CONV: begin
        rsp_s_d     = cvt_s;
        rsp_e_d     = cvt_e;
        rsp_f_d     = cvt_f;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (take) begin
            cvt_d_d = win_op;
            id_d    = win;
            ptr_d   = win_nxt;
            state_d = CONV;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cvt_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= 1'b0;
      rsp_e_q     <= '0;
      rsp_f_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cvt_d_q     <= cvt_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_e_q     <= rsp_e_d;
      rsp_f_q     <= rsp_f_d;
    end
  end

  assign cvt_d     = cvt_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_e     = rsp_e_q;
  assign rsp_f     = rsp_f_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpcvt_arb.sv
// Bench for fpcvt_arb with a behavioural FPCVT on the cvt_* ports and a
// transaction-level arbitration/response model for randomized traffic.
module tb_fpcvt_arb;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [12*N-1:0] din = '0;
  logic            rsp_ready = 1'b0;
  logic [N-1:0]    gnt;
  logic [11:0]     cvt_d;
  logic            cvt_s;
  logic [2:0]      cvt_e;
  logic [3:0]      cvt_f;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic            rsp_s;
  logic [2:0]      rsp_e;
  logic [3:0]      rsp_f;
  logic            busy;

  int n_pass = 0;
  int n_total = 0;

  fpcvt_arb #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt), .cvt_d(cvt_d),
    .cvt_s(cvt_s), .cvt_e(cvt_e), .cvt_f(cvt_f), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_e(rsp_e), .rsp_f(rsp_f),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sign-magnitude float: value ~= F * 2^E, magnitude saturated to 2047, round half up on F.
  function automatic logic [7:0] fpcvt(input logic [11:0] d);
    int v, mag, e, f;
    logic s;
    v   = int'($signed(d));
    s   = (v < 0);
    mag = s ? -v : v;
    if (mag > 2047) mag = 2047;
    e = 0;
    while (e < 7 && mag >= (16 << e)) e++;
    f = mag >> e;
    if (e > 0 && ((mag >> (e - 1)) & 1) == 1) begin
      f++;
      if (f == 16) begin
        f = 8;
        e++;
        if (e == 8) begin
          e = 7;
          f = 15;
        end
      end
    end
    return {s, 3'(e), 4'(f)};
  endfunction

  assign {cvt_s, cvt_e, cvt_f} = fpcvt(cvt_d);

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    din = {$urandom, $urandom};
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (cvt_d !== 12'h000) $display("FAIL reset_cvt_d: got %h want 000", cvt_d); else n_pass++;
    n_total++; if ({rsp_id, rsp_s, rsp_e, rsp_f} !== 10'd0)
      $display("FAIL reset_rsp_fields: got %h want 000", {rsp_id, rsp_s, rsp_e, rsp_f}); else n_pass++;
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single(input string name, input logic [11:0] v, input logic [7:0] want);
    req = 4'b0001;
    din[11:0] = v;
    rsp_ready = 1'b1;
    #1;
    n_total++; if (gnt !== 4'b0001) $display("FAIL %s_gnt: got %b want 0001", name, gnt); else n_pass++;
    @(negedge clk);
    req = '0;
    #1;
    n_total++; if (gnt !== 4'b0000) $display("FAIL %s_gnt_conv: got %b want 0000", name, gnt); else n_pass++;
    n_total++; if (cvt_d !== v) $display("FAIL %s_cvt_d: got %h want %h", name, cvt_d, v); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s_conv_flags: got valid=%b busy=%b want 0/1", name, rsp_valid, busy); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0)
      $display("FAIL %s_rsp_hdr: got valid=%b id=%0d want 1/0", name, rsp_valid, rsp_id); else n_pass++;
    n_total++; if ({rsp_s, rsp_e, rsp_f} !== want)
      $display("FAIL %s_rsp_sef: got %b want %b", name, {rsp_s, rsp_e, rsp_f}, want); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_idle: got valid=%b busy=%b want 0/0", name, rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [11:0] op [N];
    apply_reset();
    for (int i = 0; i < N; i++) begin
      op[i] = 12'($urandom);
      din[12*i +: 12] = op[i];
    end
    req = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      if (g == 0) #1;
      n_total++; if (gnt !== 4'(1 << (g % N)))
        $display("FAIL rr_gnt%0d: got %b want %b", g, gnt, 4'(1 << (g % N))); else n_pass++;
      @(negedge clk);
      #1;
      n_total++; if (gnt !== 4'b0000 || cvt_d !== op[g % N])
        $display("FAIL rr_conv%0d: got gnt=%b cvt_d=%h want 0000/%h", g, gnt, cvt_d, op[g % N]); else n_pass++;
      @(negedge clk);
      #1;
      n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g % N) || {rsp_s, rsp_e, rsp_f} !== fpcvt(op[g % N]))
        $display("FAIL rr_rsp%0d: got v=%b id=%0d sef=%h want 1/%0d/%h", g, rsp_valid, rsp_id,
                 {rsp_s, rsp_e, rsp_f}, g % N, fpcvt(op[g % N])); else n_pass++;
    end
    req = '0;
    @(negedge clk);
    #1;
    n_total++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL rr_end: got busy=%b valid=%b want 0/0", busy, rsp_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [11:0] op0, op1;
    apply_reset();
    op0 = 12'($urandom);
    op1 = 12'($urandom);
    din[11:0] = op0;
    req = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req = 4'b0010;
    din[23:12] = op1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_s, rsp_e, rsp_f} !== fpcvt(op0))
        $display("FAIL bp_hold%0d: got v=%b id=%0d sef=%h want 1/0/%h", i, rsp_valid, rsp_id,
                 {rsp_s, rsp_e, rsp_f}, fpcvt(op0)); else n_pass++;
      n_total++; if (gnt !== 4'b0000 || busy !== 1'b1)
        $display("FAIL bp_stall%0d: got gnt=%b busy=%b want 0000/1", i, gnt, busy); else n_pass++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_total++; if (gnt !== 4'b0010) $display("FAIL bp_release_gnt: got %b want 0010", gnt); else n_pass++;
    @(negedge clk);
    req = '0;
    #1;
    n_total++; if (rsp_valid !== 1'b0 || cvt_d !== op1)
      $display("FAIL bp_reload: got v=%b cvt_d=%h want 0/%h", rsp_valid, cvt_d, op1); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_s, rsp_e, rsp_f} !== fpcvt(op1))
      $display("FAIL bp_rsp1: got v=%b id=%0d sef=%h want 1/1/%h", rsp_valid, rsp_id,
               {rsp_s, rsp_e, rsp_f}, fpcvt(op1)); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_conv();
    apply_reset();
    din = {$urandom, $urandom};
    req = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    n_total++; if (gnt !== 4'b0100) $display("FAIL rc_first_gnt: got %b want 0100", gnt); else n_pass++;
    @(negedge clk);
    req = '0;
    #1;
    rst_n = 1'b0;
    req = 4'b1010;
    #1;
    n_total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cvt_d !== 12'h000 || gnt !== 4'b0000)
      $display("FAIL rc_in_reset: got v=%b busy=%b cvt_d=%h gnt=%b want 0/0/000/0000",
               rsp_valid, busy, cvt_d, gnt); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rc_no_rsp: got %b want 0", rsp_valid); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (gnt !== 4'b0010) $display("FAIL rc_ptr0_gnt: got %b want 0010", gnt); else n_pass++;
    @(negedge clk);
    req = 4'b1000;
    #1;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rc_conv_valid: got %b want 0", rsp_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1)
      $display("FAIL rc_rsp1: got v=%b id=%0d want 1/1", rsp_valid, rsp_id); else n_pass++;
    n_total++; if (gnt !== 4'b1000) $display("FAIL rc_next_gnt: got %b want 1000", gnt); else n_pass++;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3)
      $display("FAIL rc_rsp3: got v=%b id=%0d want 1/3", rsp_valid, rsp_id); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_drop();
    apply_reset();
    din = {$urandom, $urandom};
    req = 4'b0001;
    rsp_ready = 1'b0;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req = 4'b0100;
    #1;
    n_total++; if (gnt !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0)
      $display("FAIL drop_hold: got gnt=%b v=%b id=%0d want 0000/1/0", gnt, rsp_valid, rsp_id); else n_pass++;
    @(negedge clk);
    req = '0;
    rsp_ready = 1'b1;
    #1;
    n_total++; if (gnt !== 4'b0000) $display("FAIL drop_release_gnt: got %b want 0000", gnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000)
        $display("FAIL drop_quiet%0d: got v=%b busy=%b gnt=%b want 0/0/0000", i, rsp_valid, busy, gnt); else n_pass++;
    end
  endtask

  task automatic test_random();
    int ptr_m, m_id, w;
    bit have, vis, can;
    logic [7:0] m_res;
    logic [11:0] m_cvt;
    logic [N-1:0] granted;
    ptr_m = 0; m_id = 0; have = 0; vis = 0; m_res = '0; m_cvt = '0; granted = '0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && granted[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
          din[12*i +: 12] = 12'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          din[12*i +: 12] = 12'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = !have || (vis && rsp_ready);
      w = -1;
      if (can)
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      granted = (w >= 0) ? 4'(1 << w) : 4'b0000;
      n_total++; if (gnt !== granted) $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, granted); else n_pass++;
      n_total++; if (busy !== have || rsp_valid !== vis)
        $display("FAIL rnd_flags c%0d: got busy=%b v=%b want %b/%b", c, busy, rsp_valid, have, vis); else n_pass++;
      n_total++; if (cvt_d !== m_cvt) $display("FAIL rnd_cvt_d c%0d: got %h want %h", c, cvt_d, m_cvt); else n_pass++;
      if (vis) begin
        n_total++; if (rsp_id !== 2'(m_id) || {rsp_s, rsp_e, rsp_f} !== m_res)
          $display("FAIL rnd_rsp c%0d: got id=%0d sef=%h want %0d/%h", c, rsp_id, {rsp_s, rsp_e, rsp_f},
                   m_id, m_res); else n_pass++;
      end
      @(posedge clk);
      if (have && !vis) vis = 1;
      else if (vis && rsp_ready) begin
        have = 0;
        vis = 0;
      end
      if (w >= 0) begin
        have  = 1;
        vis   = 0;
        m_id  = w;
        m_cvt = din[12*w +: 12];
        m_res = fpcvt(m_cvt);
        ptr_m = (w + 1) % N;
      end
      @(negedge clk);
    end
    req = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single("pos125", 12'h07D, {1'b0, 3'd4, 4'd8});
    test_single("sat_neg", 12'h800, {1'b1, 3'd7, 4'd15});
    test_round_robin();
    test_backpressure();
    test_reset_in_conv();
    test_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
